// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, x0 constant and write-back entry type
package rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// rtl/rf_writeback_arbiter_if.sv - write-back sources, scoreboard and register-file write port
interface rf_writeback_arbiter_if #(
   parameter int DATA_W     = rf_pkg::REG_DATA_W,
   parameter int ADDR_W     = rf_pkg::REG_ADDR_W,
   parameter int FIFO_DEPTH = 4
) ();

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                   a_valid;
   logic [ADDR_W-1:0]      a_addr;
   logic [DATA_W-1:0]      a_data;
   logic                   b_valid;
   logic                   b_ready;
   logic [ADDR_W-1:0]      b_addr;
   logic [DATA_W-1:0]      b_data;
   logic                   mark_valid;
   logic [ADDR_W-1:0]      mark_addr;
   logic [2**ADDR_W-1:0]   pending;
   logic                   rg_wrt_en;
   logic [ADDR_W-1:0]      rg_wrt_addr;
   logic [DATA_W-1:0]      rg_wrt_data;
   logic [CNT_W-1:0]       fifo_count;

   // master: the arbiter; slave: the pipeline and register file around it
   modport master (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, mark_valid, mark_addr,
      output b_ready, pending, rg_wrt_en, rg_wrt_addr, rg_wrt_data, fifo_count
   );

   modport slave (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data, mark_valid, mark_addr,
      input  b_ready, pending, rg_wrt_en, rg_wrt_addr, rg_wrt_data, fifo_count
   );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with occupancy count, full/empty and async reset
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
         else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - merges ALU and long-latency results into the register-file write port
module rf_writeback_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W     = REG_DATA_W,
   parameter int ADDR_W     = REG_ADDR_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   rf_writeback_arbiter_if.master   wb
);

   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int NREG    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [ENTRY_W-1:0] head;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               a_sel;
   logic [NREG-1:0]    pending_q;
   logic [NREG-1:0]    pending_d;
   logic               en_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;

   assign head_addr = head[ENTRY_W-1 -: ADDR_W];
   assign head_data = head[DATA_W-1:0];

   // A results to x0 do not claim the port, so B may drain in that cycle
   assign a_sel      = wb.a_valid && (wb.a_addr != ZERO);
   assign pop        = !a_sel && !fifo_empty;
   assign push       = wb.b_valid && !fifo_full;
   assign wb.b_ready = !fifo_full;

   wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({wb.b_addr, wb.b_data}),
      .pop       (pop),
      .head_data (head),
      .count     (wb.fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // set is applied after clear so a same-cycle re-mark keeps the bit high
   always_comb begin
      pending_d = pending_q;
      if (pop && head_addr != ZERO)
         pending_d[head_addr] = 1'b0;
      if (wb.mark_valid && wb.mark_addr != ZERO)
         pending_d[wb.mark_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         en_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (a_sel) begin
            en_q   <= 1'b1;
            addr_q <= wb.a_addr;
            data_q <= wb.a_data;
         end else if (!fifo_empty) begin
            en_q   <= (head_addr != ZERO);
            addr_q <= head_addr;
            data_q <= head_data;
         end else begin
            en_q   <= 1'b0;
         end
      end
   end

   assign wb.pending     = pending_q;
   assign wb.rg_wrt_en   = en_q;
   assign wb.rg_wrt_addr = addr_q;
   assign wb.rg_wrt_data = data_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - directed vector bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rf_writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) wb ();

   rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic        mv;
      logic [4:0]  ma;
      logic        e_en;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
      logic        e_rdy;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic vec_t mk(
      input logic av, input logic [4:0] aa, input logic [31:0] ad,
      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
      input logic mv, input logic [4:0] ma,
      input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_data,
      input logic [2:0] e_cnt, input logic e_rdy, input logic [31:0] e_pend);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad;
      v.bv = bv; v.ba = ba; v.bd = bd;
      v.mv = mv; v.ma = ma;
      v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
      v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic mv, input logic [4:0] ma);
      wb.a_valid = av; wb.a_addr = aa; wb.a_data = ad;
      wb.b_valid = bv; wb.b_addr = ba; wb.b_data = bd;
      wb.mark_valid = mv; wb.mark_addr = ma;
   endtask

   task automatic check_all(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [2:0] cnt,
                            input logic rdy, input logic [31:0] pend);
      check({tag, " en"},    32'(wb.rg_wrt_en),   32'(en));
      check({tag, " addr"},  32'(wb.rg_wrt_addr), 32'(addr));
      check({tag, " data"},  wb.rg_wrt_data,      data);
      check({tag, " count"}, 32'(wb.fifo_count),  32'(cnt));
      check({tag, " ready"}, 32'(wb.b_ready),     32'(rdy));
      check({tag, " pend"},  wb.pending,          pend);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // A priority over a buffered B result, pending[9] clears on the B write
      vecs.push_back(mk(1, 1, 32'h11, 1, 9, 32'hDEAD, 1, 9,  1, 1, 32'h11,   1, 1, 32'h200));
      vecs.push_back(mk(1, 1, 32'h12, 0, 0, 0,        0, 0,  1, 1, 32'h12,   1, 1, 32'h200));
      vecs.push_back(mk(1, 1, 32'h13, 0, 0, 0,        0, 0,  1, 1, 32'h13,   1, 1, 32'h200));
      vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0,        0, 0,  1, 1, 32'h14,   1, 1, 32'h200));
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,        0, 0,  1, 9, 32'hDEAD, 0, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,        0, 0,  0, 9, 32'hDEAD, 0, 1, 32'h0));
      // fill to full under A traffic, fifth beat held until A idles
      vecs.push_back(mk(1, 2, 32'h20, 1, 10, 32'hA0,   0, 0, 1, 2,  32'h20,   1, 1, 0));
      vecs.push_back(mk(1, 2, 32'h21, 1, 11, 32'hA1,   0, 0, 1, 2,  32'h21,   2, 1, 0));
      vecs.push_back(mk(1, 2, 32'h22, 1, 12, 32'hA2,   0, 0, 1, 2,  32'h22,   3, 1, 0));
      vecs.push_back(mk(1, 2, 32'h23, 1, 13, 32'hA3,   0, 0, 1, 2,  32'h23,   4, 0, 0));
      vecs.push_back(mk(1, 2, 32'h24, 1, 14, 32'hBEEF, 0, 0, 1, 2,  32'h24,   4, 0, 0));
      vecs.push_back(mk(0, 0, 0,      1, 14, 32'hBEEF, 0, 0, 1, 10, 32'hA0,   3, 1, 0));
      vecs.push_back(mk(0, 0, 0,      1, 14, 32'hBEEF, 0, 0, 1, 11, 32'hA1,   3, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0,  0,        0, 0, 1, 12, 32'hA2,   2, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0,  0,        0, 0, 1, 13, 32'hA3,   1, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0,  0,        0, 0, 1, 14, 32'hBEEF, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0,  0,        0, 0, 0, 14, 32'hBEEF, 0, 1, 0));
      // x0 suppression on both sources and on mark
      vecs.push_back(mk(1, 0, 32'hFFFF_FFFF, 1, 0, 32'h77, 1, 0, 0, 14, 32'hBEEF, 1, 1, 0));
      vecs.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,      1, 0, 0, 0,  32'h77,   0, 1, 0));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,      0, 0, 0, 0,  32'h77,   0, 1, 0));
      // set/clear collision on x8
      vecs.push_back(mk(0, 0, 0, 1, 8, 32'h55, 1, 8, 0, 0, 32'h77, 1, 1, 32'h100));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      1, 8, 1, 8, 32'h55, 0, 1, 32'h100));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 8, 32'h55, 0, 1, 32'h100));
      vecs.push_back(mk(0, 0, 0, 1, 8, 32'h56, 0, 0, 0, 8, 32'h55, 1, 1, 32'h100));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 1, 8, 32'h56, 0, 1, 32'h0));
      // simultaneous push and pop at count 2
      vecs.push_back(mk(1, 1, 32'hA1, 1, 3, 32'h31, 0, 0, 1, 1, 32'hA1, 1, 1, 0));
      vecs.push_back(mk(1, 1, 32'hA2, 1, 4, 32'h41, 0, 0, 1, 1, 32'hA2, 2, 1, 0));
      vecs.push_back(mk(0, 0, 0,      1, 5, 32'h51, 0, 0, 1, 3, 32'h31, 2, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 1, 4, 32'h41, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 1, 5, 32'h51, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 5, 32'h51, 0, 1, 0));

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0, 1, 0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
               vecs[i].mv, vecs[i].ma);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data,
                   vecs[i].e_cnt, vecs[i].e_rdy, vecs[i].e_pend);
      end

      // reset mid-stream with three buffered B entries outstanding
      drive(1, 1, 32'h61, 1, 5, 32'h5A, 1, 5);
      @(posedge clk); #1;
      drive(1, 1, 32'h62, 1, 6, 32'h6A, 1, 6);
      @(posedge clk); #1;
      drive(1, 1, 32'h63, 1, 7, 32'h7A, 1, 7);
      @(posedge clk); #1;
      check_all("pre_reset", 1, 1, 32'h63, 3, 1, 32'hE0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset count", 32'(wb.fifo_count), 32'h0);
      @(posedge clk); #1;
      check_all("mid_reset", 0, 0, 0, 0, 1, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("post_reset%0d", i), 0, 0, 0, 0, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side master for the register file: merges single-cycle ALU results (source A) and long-latency results from load/multiply (source B) into the one register-file write port.
- Buffers B results in a small FIFO.
- Suppresses writes to x0.
- Keeps a pending-destination scoreboard so decode can stall on RAW hazards against in-flight long-latency ops.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 4, source-B buffer entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  ALU result valid this cycle; always accepted, no ready
- a_addr  in  ADDR_W  ALU destination register
- a_data  in  DATA_W  ALU result
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept; equals !full
- b_addr  in  ADDR_W  long-latency destination register
- b_data  in  DATA_W  long-latency result
- mark_valid  in  1  decode issued a long-latency op this cycle
- mark_addr  in  ADDR_W  its destination register
- pending  out  2**ADDR_W  per-register in-flight flag; bit 0 always 0
- rg_wrt_en  out  1  register-file write enable (registered)
- rg_wrt_addr  out  ADDR_W  register-file write address (registered)
- rg_wrt_data  out  DATA_W  register-file write data (registered)
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset, asynchronous and immediate, regardless of any in-flight operation:
  - rg_wrt_en/addr/data = 0
  - FIFO emptied, fifo_count = 0
  - pending = 0
  - b_ready = 1 (combinational from count)
  - Buffered B results are discarded.
- B accept: the B handshake fires when b_valid && b_ready at a rising edge; the entry {b_addr,b_data} is pushed.
- Per-cycle write selection; one write per cycle, decided at the rising edge:
  1. If a_valid && a_addr!=0: output regs load {1,a_addr,a_data}. The FIFO does not pop.
  2. Else if FIFO non-empty: pop the head. Load {head_addr!=0, head_addr, head_data}; a popped x0 entry is dropped with rg_wrt_en=0.
  3. Else: rg_wrt_en=0. addr/data hold their previous values.
- Latency:
  - A result reaches the register file one cycle after a_valid.
  - A B result reaches it no sooner than one cycle after its handshake.
- Ordering and throughput:
  - No bypass from B input to output. A B beat accepted in cycle n is earliest written in cycle n+1 (pushed, then popped).
  - B entries retire strictly in FIFO order.
  - Starvation of B under continuous A traffic is permitted. Decode bounds it by stalling on pending.
- Simultaneous push and pop: both occur and count is unchanged. A full FIFO is not freed for a same-cycle push (b_ready depends on count only).
- Full: b_ready=0 when count==FIFO_DEPTH. A b_valid held high while b_ready=0 is not pushed. The source must hold its data until the handshake fires.
- Empty: a pop request with count==0 is not possible by construction. The head is never read when empty.
- Pointers are ADDR-independent, log2(FIFO_DEPTH) bits, and wrap modulo FIFO_DEPTH.
- Scoreboard, per bit r, evaluated at each edge:
  - set when mark_valid && mark_addr==r && r!=0
  - cleared when a B-sourced write to r is issued to the output regs
  - simultaneous set and clear of the same r: set wins, so the bit stays 1
  - A-sourced writes never clear pending
- Hazard contract, enforced by decode and not checked here:
  - no A write to a register whose pending bit is 1
  - at most one outstanding long-latency op per destination
- X0: never written, never pending. rg_wrt_en is never 1 with rg_wrt_addr==0.

Decomposition:
- Shared package rf_pkg holds:
  - the REG_ADDR_W/REG_DATA_W constants
  - the wb_entry_t struct {addr, data}
  - the REG_ZERO constant
- Sub-module wb_fifo implements a parameterised synchronous FIFO with count, full/empty, and async reset.
- The arbiter itself holds the select logic, output registers and scoreboard.

Test Plan:
- Reset mid-stream: push 3 B entries with mark x5,x6,x7, then assert reset -> next cycle rg_wrt_en=0, fifo_count=0, pending=0, b_ready=1. After release no stale write appears.
- A priority: a_valid every cycle to x1 (values 0x11..0x14) while B pushes {x9,0xDEAD} -> four writes to x1 in order. x9 is written 0xDEAD the first cycle a_valid drops, and pending[9] clears that same edge.
- Full FIFO: hold a_valid=1 (x2) and push B to x10..x13 -> b_ready=0 after the 4th push. A 5th beat {x14,0xBEEF} is held and not accepted until A idles. Writes then come out x10,x11,x12,x13,x14 in order.
- X0 suppression: a_valid with a_addr=0, data 0xFFFF_FFFF; B push to x0; mark x0 -> rg_wrt_en never 1 and pending[0] stays 0. The B x0 entry is popped, so fifo_count returns to 0.
- Set/clear collision: mark x8, push B {x8,0x55}. In the cycle it pops, assert mark_valid for x8 again -> write x8=0x55 and pending[8] remains 1.
- Simultaneous push/pop at count=2: a_valid=0, b_valid=1 -> one pop written, fifo_count stays 2.
